mem1r1w_port_arbiter: RTL and testbench

- Shares the single read port and single write port of the 1R1W difftest RAM helper between NUM_REQ requesters.
- Each port has its own round-robin arbiter. Every requester uses valid/ready handshakes.
- Read data returns with a fixed 1-cycle latency, whether the helper is in sync mode (r_0_async=0) or async mode (r_0_async=1).
- Also handles same-index read/write hazards, expands byte strobes to bit masks, range-checks indices, and keeps a hazard-stall counter.

---
 rtl/mem1r1w_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem1r1w_port_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem1r1w_port_arbiter.sv
// Shares one read and one write port of a 1R1W RAM among NUM_REQ requesters.
// Each port uses its own round-robin arbiter. Read data returns one cycle after the grant.
module mem1r1w_port_arbiter #(
    parameter int          NUM_REQ  = 2,
    parameter int          ADDR_W   = 32,
    parameter logic [63:0] RAM_SIZE = 64'h8000_0000
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        rd_req_valid,
    output logic [NUM_REQ-1:0]        rd_req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] rd_req_index,
    output logic [NUM_REQ-1:0]        rd_resp_valid,
    output logic [63:0]               rd_resp_data,
    input  logic [NUM_REQ-1:0]        wr_req_valid,
    output logic [NUM_REQ-1:0]        wr_req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] wr_req_index,
    input  logic [NUM_REQ*64-1:0]     wr_req_data,
    input  logic [NUM_REQ*8-1:0]      wr_req_strb,
    output logic                      mem_r_enable,
    output logic [63:0]               mem_r_index,
    input  logic [63:0]               mem_r_data,
    input  logic                      mem_r_async,
    output logic                      mem_w_enable,
    output logic [63:0]               mem_w_index,
    output logic [63:0]               mem_w_data,
    output logic [63:0]               mem_w_mask,
    output logic                      range_err,
    output logic [31:0]               stall_cnt
);

    localparam int          PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [63:0] NWORDS  = RAM_SIZE >> 3;
    localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);

    // Returns {found, index}; search starts one past the pointer and wraps.
    function automatic logic [PW:0] f_rr(
        input logic [NUM_REQ-1:0] v,
        input logic [PW-1:0]      p
    );
        logic [PW:0] res;
        int          k;
        res = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(p) + i) % NUM_REQ;
            if (!res[PW] && v[k]) begin
                res = {1'b1, PW'(k)};
            end
        end
        return res;
    endfunction

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_tag;
    logic              r_tag_vld;
    logic              r_oor;
    logic [63:0]       r_rdata;
    logic              r_range_err;
    logic [31:0]       r_stall;

    logic [PW:0]       w_wr_pick;
    logic [PW:0]       w_rd_pick;
    logic              w_wr_found;
    logic              w_rd_found;
    logic [PW-1:0]     w_wr_sel;
    logic [PW-1:0]     w_rd_sel;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [ADDR_W-1:0] w_rd_idx;
    logic [63:0]       w_wr_dat;
    logic [7:0]        w_wr_strb;
    logic              w_wr_oor;
    logic              w_rd_oor;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_hazard;

    assign w_wr_pick  = f_rr(wr_req_valid, r_wr_ptr);
    assign w_rd_pick  = f_rr(rd_req_valid, r_rd_ptr);
    assign w_wr_found = w_wr_pick[PW];
    assign w_rd_found = w_rd_pick[PW];
    assign w_wr_sel   = w_wr_pick[PW-1:0];
    assign w_rd_sel   = w_rd_pick[PW-1:0];

    assign w_wr_idx  = wr_req_index[int'(w_wr_sel)*ADDR_W +: ADDR_W];
    assign w_rd_idx  = rd_req_index[int'(w_rd_sel)*ADDR_W +: ADDR_W];
    assign w_wr_dat  = wr_req_data[int'(w_wr_sel)*64 +: 64];
    assign w_wr_strb = wr_req_strb[int'(w_wr_sel)*8 +: 8];

    assign w_wr_oor = (64'(w_wr_idx) >= NWORDS);
    assign w_rd_oor = (64'(w_rd_idx) >= NWORDS);

    // A read to the index being written this cycle waits one cycle so it sees the new data.
    assign w_wr_fire = reset_n & w_wr_found;
    assign w_hazard  = w_wr_fire & w_rd_found & (w_rd_idx == w_wr_idx);
    assign w_rd_fire = reset_n & w_rd_found & ~w_hazard;

    assign wr_req_ready = w_wr_fire ? (NUM_REQ'(1) << w_wr_sel) : '0;
    assign rd_req_ready = w_rd_fire ? (NUM_REQ'(1) << w_rd_sel) : '0;

    assign mem_w_enable = w_wr_fire & ~w_wr_oor;
    assign mem_w_index  = mem_w_enable ? 64'(w_wr_idx) : '0;
    assign mem_w_data   = mem_w_enable ? w_wr_dat : '0;

    always_comb begin
        mem_w_mask = '0;
        for (int k = 0; k < 8; k++) begin
            mem_w_mask[k*8 +: 8] = {8{w_wr_strb[k] & mem_w_enable}};
        end
    end

    assign mem_r_enable = w_rd_fire & ~w_rd_oor;
    assign mem_r_index  = mem_r_enable ? 64'(w_rd_idx) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= PTR_RST;
            r_rd_ptr    <= PTR_RST;
            r_tag       <= '0;
            r_tag_vld   <= 1'b0;
            r_oor       <= 1'b0;
            r_rdata     <= '0;
            r_range_err <= 1'b0;
            r_stall     <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= w_wr_sel;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= w_rd_sel;
                r_tag    <= w_rd_sel;
                r_oor    <= w_rd_oor;
            end
            r_tag_vld <= w_rd_fire;
            // Async helper presents data in the grant cycle; hold it for the response cycle.
            if (w_rd_fire && mem_r_async) begin
                r_rdata <= mem_r_data;
            end
            if ((w_rd_fire && w_rd_oor) || (w_wr_fire && w_wr_oor)) begin
                r_range_err <= 1'b1;
            end
            if (w_hazard && (r_stall != 32'hFFFF_FFFF)) begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end

    assign rd_resp_valid = (reset_n && r_tag_vld) ? (NUM_REQ'(1) << r_tag) : '0;

    always_comb begin
        rd_resp_data = '0;
        if (reset_n && r_tag_vld && !r_oor) begin
            rd_resp_data = mem_r_async ? r_rdata : mem_r_data;
        end
    end

    assign range_err = reset_n & r_range_err;
    assign stall_cnt = reset_n ? r_stall : '0;

endmodule

// File: tb/tb_mem1r1w_port_arbiter.sv
// Directed bench for mem1r1w_port_arbiter with an 8-word RAM and a
// behavioural 1R1W helper model that supports sync and async read modes.
module tb_mem1r1w_port_arbiter;

    logic         clock;
    logic         reset_n;
    logic [1:0]   rd_req_valid;
    logic [1:0]   rd_req_ready;
    logic [63:0]  rd_req_index;
    logic [1:0]   rd_resp_valid;
    logic [63:0]  rd_resp_data;
    logic [1:0]   wr_req_valid;
    logic [1:0]   wr_req_ready;
    logic [63:0]  wr_req_index;
    logic [127:0] wr_req_data;
    logic [15:0]  wr_req_strb;
    logic         mem_r_enable;
    logic [63:0]  mem_r_index;
    logic [63:0]  mem_r_data;
    logic         mem_r_async;
    logic         mem_w_enable;
    logic [63:0]  mem_w_index;
    logic [63:0]  mem_w_data;
    logic [63:0]  mem_w_mask;
    logic         range_err;
    logic [31:0]  stall_cnt;

    int n_chk;
    int n_err;

    logic [63:0] r_mem [16];
    logic [63:0] r_q;

    mem1r1w_port_arbiter #(
        .NUM_REQ (2),
        .ADDR_W  (32),
        .RAM_SIZE(64'd64)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_index (rd_req_index),
        .rd_resp_valid(rd_resp_valid),
        .rd_resp_data (rd_resp_data),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_index (wr_req_index),
        .wr_req_data  (wr_req_data),
        .wr_req_strb  (wr_req_strb),
        .mem_r_enable (mem_r_enable),
        .mem_r_index  (mem_r_index),
        .mem_r_data   (mem_r_data),
        .mem_r_async  (mem_r_async),
        .mem_w_enable (mem_w_enable),
        .mem_w_index  (mem_w_index),
        .mem_w_data   (mem_w_data),
        .mem_w_mask   (mem_w_mask),
        .range_err    (range_err),
        .stall_cnt    (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_w_enable) begin
            r_mem[mem_w_index[3:0]] <= (r_mem[mem_w_index[3:0]] & ~mem_w_mask)
                                     | (mem_w_data & mem_w_mask);
        end
        if (mem_r_enable) begin
            r_q <= r_mem[mem_r_index[3:0]];
        end
    end

    assign mem_r_data = mem_r_async ? r_mem[mem_r_index[3:0]] : r_q;

    task automatic clear_inputs();
        rd_req_valid = '0;
        rd_req_index = '0;
        wr_req_valid = '0;
        wr_req_index = '0;
        wr_req_data  = '0;
        wr_req_strb  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n     = 1'b0;
        mem_r_async = 1'b0;
        r_q         = '0;
        for (int i = 0; i < 16; i++) r_mem[i] = 64'h0;
        rd_req_valid = 2'b11;
        wr_req_valid = 2'b11;
        #3;
        n_chk++;
        if (rd_req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL rst_rd_ready: got %b want 00", rd_req_ready);
        end
        n_chk++;
        if (wr_req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL rst_wr_ready: got %b want 00", wr_req_ready);
        end
        n_chk++;
        if (rd_resp_valid !== 2'b00) begin
            n_err++;
            $display("FAIL rst_resp_valid: got %b want 00", rd_resp_valid);
        end
        n_chk++;
        if ({mem_r_enable, mem_w_enable, range_err} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_enables: got %b want 000",
                     {mem_r_enable, mem_w_enable, range_err});
        end
        n_chk++;
        if (stall_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL rst_stall: got %0d want 0", stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_single_read(input logic async_mode);
        mem_r_async = async_mode;
        do_reset();
        wr_req_valid       = 2'b01;
        wr_req_index[31:0] = 32'd5;
        wr_req_data[63:0]  = 64'hDEAD_BEEF;
        wr_req_strb[7:0]   = 8'hFF;
        @(posedge clock); #1;
        wr_req_valid       = 2'b00;
        rd_req_valid       = 2'b01;
        rd_req_index[31:0] = 32'd5;
        #1;
        n_chk++;
        if (rd_req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL read%0d_ready: got %b want 01", async_mode, rd_req_ready);
        end
        n_chk++;
        if (mem_r_enable !== 1'b1) begin
            n_err++;
            $display("FAIL read%0d_ren: got %b want 1", async_mode, mem_r_enable);
        end
        n_chk++;
        if (mem_r_index !== 64'd5) begin
            n_err++;
            $display("FAIL read%0d_rindex: got %0d want 5", async_mode, mem_r_index);
        end
        @(posedge clock); #1;
        rd_req_valid = 2'b00;
        #1;
        n_chk++;
        if (rd_resp_valid !== 2'b01) begin
            n_err++;
            $display("FAIL read%0d_resp_valid: got %b want 01", async_mode, rd_resp_valid);
        end
        n_chk++;
        if (rd_resp_data !== 64'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL read%0d_data: got %h want deadbeef", async_mode, rd_resp_data);
        end
        @(posedge clock); #1;
        n_chk++;
        if (rd_resp_valid !== 2'b00) begin
            n_err++;
            $display("FAIL read%0d_resp_once: got %b want 00", async_mode, rd_resp_valid);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        mem_r_async = 1'b0;
        do_reset();
        prev_g       = 2'b00;
        rd_req_index = {32'd2, 32'd1};
        rd_req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            n_chk++;
            if (rd_req_ready !== exp_g) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got %b want %b", c, rd_req_ready, exp_g);
            end
            if (c > 0) begin
                n_chk++;
                if (rd_resp_valid !== prev_g) begin
                    n_err++;
                    $display("FAIL rr_tag[%0d]: got %b want %b", c, rd_resp_valid, prev_g);
                end
            end
            prev_g = exp_g;
            @(posedge clock); #1;
        end
        rd_req_valid = 2'b00;
        #1;
        n_chk++;
        if (rd_resp_valid !== 2'b10) begin
            n_err++;
            $display("FAIL rr_tag_last: got %b want 10", rd_resp_valid);
        end
    endtask

    task automatic test_byte_strobe();
        mem_r_async = 1'b0;
        do_reset();
        wr_req_valid         = 2'b10;
        wr_req_index[63:32]  = 32'd3;
        wr_req_data[127:64]  = 64'h1122_3344_5566_7788;
        wr_req_strb[15:8]    = 8'b0000_0101;
        #1;
        n_chk++;
        if (wr_req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL strb_ready: got %b want 10", wr_req_ready);
        end
        n_chk++;
        if (mem_w_enable !== 1'b1 || mem_w_index !== 64'd3) begin
            n_err++;
            $display("FAIL strb_wen_idx: got %b/%0d want 1/3", mem_w_enable, mem_w_index);
        end
        n_chk++;
        if (mem_w_mask !== 64'h0000_0000_00FF_00FF) begin
            n_err++;
            $display("FAIL strb_mask: got %h want 00000000_00ff00ff", mem_w_mask);
        end
        n_chk++;
        if (mem_w_data !== 64'h1122_3344_5566_7788) begin
            n_err++;
            $display("FAIL strb_wdata: got %h want 1122334455667788", mem_w_data);
        end
        @(posedge clock); #1;
        wr_req_valid       = 2'b00;
        rd_req_valid       = 2'b01;
        rd_req_index[31:0] = 32'd3;
        @(posedge clock); #1;
        rd_req_valid = 2'b00;
        #1;
        n_chk++;
        if (rd_resp_data !== 64'h0000_0000_0066_0088) begin
            n_err++;
            $display("FAIL strb_readback: got %h want 00000000_00660088", rd_resp_data);
        end
    endtask

    task automatic test_hazard();
        mem_r_async = 1'b0;
        do_reset();
        wr_req_valid        = 2'b01;
        wr_req_index[31:0]  = 32'd7;
        wr_req_data[63:0]   = 64'h0123_4567_89AB_CDEF;
        wr_req_strb[7:0]    = 8'hFF;
        rd_req_valid        = 2'b10;
        rd_req_index[63:32] = 32'd7;
        #1;
        n_chk++;
        if (wr_req_ready !== 2'b01 || rd_req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL haz_t_ready: got wr=%b rd=%b want wr=01 rd=00",
                     wr_req_ready, rd_req_ready);
        end
        n_chk++;
        if (mem_r_enable !== 1'b0) begin
            n_err++;
            $display("FAIL haz_t_ren: got %b want 0", mem_r_enable);
        end
        @(posedge clock); #1;
        wr_req_valid = 2'b00;
        #1;
        n_chk++;
        if (rd_req_ready !== 2'b10 || mem_r_enable !== 1'b1) begin
            n_err++;
            $display("FAIL haz_t1_grant: got rd=%b ren=%b want rd=10 ren=1",
                     rd_req_ready, mem_r_enable);
        end
        n_chk++;
        if (stall_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL haz_stall: got %0d want 1", stall_cnt);
        end
        @(posedge clock); #1;
        rd_req_valid = 2'b00;
        #1;
        n_chk++;
        if (rd_resp_valid !== 2'b10 || rd_resp_data !== 64'h0123_4567_89AB_CDEF) begin
            n_err++;
            $display("FAIL haz_resp: got %b/%h want 10/0123456789abcdef",
                     rd_resp_valid, rd_resp_data);
        end
        n_chk++;
        if (stall_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL haz_stall_hold: got %0d want 1", stall_cnt);
        end
    endtask

    task automatic test_concurrent();
        wr_req_valid        = 2'b01;
        wr_req_index[31:0]  = 32'd2;
        wr_req_data[63:0]   = 64'h5555_AAAA_5555_AAAA;
        wr_req_strb[7:0]    = 8'hFF;
        rd_req_valid        = 2'b10;
        rd_req_index[63:32] = 32'd7;
        #1;
        n_chk++;
        if ({wr_req_ready, rd_req_ready} !== 4'b0110) begin
            n_err++;
            $display("FAIL conc_ready: got wr=%b rd=%b want wr=01 rd=10",
                     wr_req_ready, rd_req_ready);
        end
        n_chk++;
        if ({mem_w_enable, mem_r_enable} !== 2'b11) begin
            n_err++;
            $display("FAIL conc_en: got %b want 11", {mem_w_enable, mem_r_enable});
        end
        @(posedge clock); #1;
        clear_inputs();
        #1;
        n_chk++;
        if (rd_resp_data !== 64'h0123_4567_89AB_CDEF || stall_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL conc_resp: got %h stall=%0d want 0123456789abcdef stall=1",
                     rd_resp_data, stall_cnt);
        end
    endtask

    task automatic test_range();
        mem_r_async = 1'b0;
        do_reset();
        rd_req_valid        = 2'b01;
        rd_req_index[31:0]  = 32'd8;
        wr_req_valid        = 2'b10;
        wr_req_index[63:32] = 32'd9;
        wr_req_data[127:64] = 64'hFFFF_FFFF_FFFF_FFFF;
        wr_req_strb[15:8]   = 8'hFF;
        #1;
        n_chk++;
        if (rd_req_ready !== 2'b01 || wr_req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL range_ready: got rd=%b wr=%b want rd=01 wr=10",
                     rd_req_ready, wr_req_ready);
        end
        n_chk++;
        if ({mem_r_enable, mem_w_enable} !== 2'b00) begin
            n_err++;
            $display("FAIL range_en: got %b want 00", {mem_r_enable, mem_w_enable});
        end
        @(posedge clock); #1;
        clear_inputs();
        #1;
        n_chk++;
        if (rd_resp_valid !== 2'b01 || rd_resp_data !== 64'h0) begin
            n_err++;
            $display("FAIL range_resp: got %b/%h want 01/0", rd_resp_valid, rd_resp_data);
        end
        n_chk++;
        if (range_err !== 1'b1) begin
            n_err++;
            $display("FAIL range_err_set: got %b want 1", range_err);
        end
        repeat (3) @(posedge clock);
        #1;
        n_chk++;
        if (range_err !== 1'b1) begin
            n_err++;
            $display("FAIL range_err_sticky: got %b want 1", range_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        #1;
        n_chk++;
        if (range_err !== 1'b0) begin
            n_err++;
            $display("FAIL mid_range_clr: got %b want 0", range_err);
        end
        rd_req_valid        = 2'b10;
        rd_req_index[63:32] = 32'd7;
        #1;
        n_chk++;
        if (rd_req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL mid_grant: got %b want 10", rd_req_ready);
        end
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (rd_resp_valid !== 2'b00 || rd_req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL mid_gate: got resp=%b rdy=%b want 00/00",
                     rd_resp_valid, rd_req_ready);
        end
        n_chk++;
        if ({mem_r_enable, mem_w_enable} !== 2'b00) begin
            n_err++;
            $display("FAIL mid_gate_en: got %b want 00", {mem_r_enable, mem_w_enable});
        end
        repeat (2) @(posedge clock);
        #1;
        reset_n            = 1'b1;
        rd_req_valid       = 2'b11;
        rd_req_index[31:0] = 32'd5;
        #1;
        n_chk++;
        if (rd_resp_valid !== 2'b00) begin
            n_err++;
            $display("FAIL mid_stray: got %b want 00", rd_resp_valid);
        end
        n_chk++;
        if (rd_req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL mid_first: got %b want 01", rd_req_ready);
        end
        @(posedge clock); #1;
        clear_inputs();
        #1;
        n_chk++;
        if (rd_resp_valid !== 2'b01 || rd_resp_data !== 64'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL mid_resp: got %b/%h want 01/deadbeef",
                     rd_resp_valid, rd_resp_data);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        test_reset();
        test_single_read(1'b0);
        test_single_read(1'b1);
        test_fairness();
        test_byte_strobe();
        test_hazard();
        test_concurrent();
        test_range();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
